// File: rtl/pcs_decoder_64b66b.sv
// 10GBASE-R receive 64b/66b decoder: classifies 66-bit blocks, runs the RX state
// machine with one-block lookahead and emits registered XGMII words.
module pcs_decoder_64b66b #(
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [1:0]               i_rx_header,
  input  logic [63:0]              i_rx_data,
  input  logic                     i_rx_valid,
  input  logic                     i_block_lock,
  output logic [63:0]              o_xgmii_rxd,
  output logic [7:0]               o_xgmii_rxc,
  output logic                     o_xgmii_valid,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned LANES  = 8;

  localparam logic [1:0]        SYNC_DATA  = 2'b10;
  localparam logic [1:0]        SYNC_CTL   = 2'b01;
  localparam logic [DATA_W-1:0] LBLOCK_RXD = 64'h0100009C_0100009C;
  localparam logic [LANES-1:0]  LBLOCK_RXC = 8'h11;
  localparam logic [DATA_W-1:0] ERR_RXD    = {LANES{8'hFE}};

  typedef enum logic [2:0] {BT_C, BT_S, BT_D, BT_T, BT_E} blk_type_e;
  typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_e;

  function automatic logic code_valid(input logic [6:0] c);
    case (c)
      7'h00, 7'h06, 7'h1e, 7'h2d, 7'h33, 7'h4b, 7'h55, 7'h66, 7'h78: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] ctl_to_rs(input logic [6:0] c);
    case (c)
      7'h00:   return 8'h07;
      7'h06:   return 8'h06;
      7'h2d:   return 8'h1C;
      7'h33:   return 8'h3C;
      7'h4b:   return 8'h7C;
      7'h55:   return 8'hBC;
      7'h66:   return 8'hDC;
      7'h78:   return 8'hF7;
      default: return 8'hFE;
    endcase
  endfunction

  function automatic logic [7:0] oc_to_rs(input logic [3:0] o);
    case (o)
      4'h0:    return 8'h9C;
      4'hF:    return 8'h5C;
      default: return 8'hFE;
    endcase
  endfunction

  // Lane index of the /T/ character for terminate block types
  function automatic logic [2:0] t_lane(input logic [7:0] bt);
    case (bt)
      8'h87:   return 3'd0;
      8'h99:   return 3'd1;
      8'haa:   return 3'd2;
      8'hb4:   return 3'd3;
      8'hcc:   return 3'd4;
      8'hd2:   return 3'd5;
      8'he1:   return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  function automatic blk_type_e classify(input logic [1:0] hdr, input logic [63:0] d);
    logic all_ok;
    all_ok = 1'b1;
    for (int k = 0; k < 8; k++) all_ok &= code_valid(d[8+7*k +: 7]);
    if (hdr == SYNC_DATA) return BT_D;
    if (hdr != SYNC_CTL) return BT_E;
    case (d[7:0])
      8'h1e:                      return all_ok ? BT_C : BT_E;
      8'h2d, 8'h55, 8'h4b:        return BT_C;
      8'h33, 8'h66, 8'h78:        return BT_S;
      8'h87, 8'h99, 8'haa, 8'hb4,
      8'hcc, 8'hd2, 8'he1, 8'hff: return BT_T;
      default:                    return BT_E;
    endcase
  endfunction

  // Returns {rxc, rxd} for a block already known not to be an error block
  function automatic logic [71:0] decode(input logic is_data, input logic [63:0] d);
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic [63:0] dsh;
    logic [2:0]  n;
    rxd = ERR_RXD;
    rxc = 8'hFF;
    dsh = d >> 8;
    n   = t_lane(d[7:0]);
    if (is_data) begin
      rxd = d;
      rxc = 8'h00;
    end else begin
      case (d[7:0])
        8'h1e: for (int k = 0; k < 8; k++) rxd[8*k +: 8] = ctl_to_rs(d[8+7*k +: 7]);
        8'h2d, 8'h33: begin
          for (int k = 0; k < 4; k++) rxd[8*k +: 8] = ctl_to_rs(d[8+7*k +: 7]);
          rxd[39:32] = (d[7:0] == 8'h2d) ? oc_to_rs(d[39:36]) : 8'hFB;
          rxd[63:40] = d[63:40];
          rxc        = 8'h1F;
        end
        8'h66, 8'h55: begin
          rxd[7:0]   = oc_to_rs(d[35:32]);
          rxd[31:8]  = d[31:8];
          rxd[39:32] = (d[7:0] == 8'h55) ? oc_to_rs(d[39:36]) : 8'hFB;
          rxd[63:40] = d[63:40];
          rxc        = 8'h11;
        end
        8'h78: begin
          rxd = {d[63:8], 8'hFB};
          rxc = 8'h01;
        end
        8'h4b: begin
          rxd[7:0]  = oc_to_rs(d[35:32]);
          rxd[31:8] = d[31:8];
          for (int k = 4; k < 8; k++) rxd[8*k +: 8] = ctl_to_rs(d[8+7*k +: 7]);
          rxc = 8'hF1;
        end
        8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff: begin
          for (int k = 0; k < 8; k++) begin
            if (3'(k) < n) begin
              rxd[8*k +: 8] = dsh[8*k +: 8];
              rxc[k]        = 1'b0;
            end else if (3'(k) == n) begin
              rxd[8*k +: 8] = 8'hFD;
            end else begin
              rxd[8*k +: 8] = ctl_to_rs(d[8+7*k +: 7]);
            end
          end
        end
        default: ;
      endcase
    end
    return {rxc, rxd};
  endfunction

  rx_state_e                r_state;
  logic                     r_a_full;
  logic [63:0]              r_a_data;
  blk_type_e                r_a_type;
  logic [63:0]              r_rxd;
  logic [7:0]               r_rxc;
  logic                     r_valid;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;

  rx_state_e                w_state_nxt;
  rx_state_e                w_fsm_state;
  logic                     w_a_full_nxt;
  logic [63:0]              w_a_data_nxt;
  blk_type_e                w_a_type_nxt;
  logic [63:0]              w_rxd_nxt;
  logic [7:0]               w_rxc_nxt;
  logic [ERR_CNT_WIDTH-1:0] w_err_nxt;
  blk_type_e                w_in_type;
  logic                     w_term_ok;
  logic [71:0]              w_dec_word;

  assign w_in_type  = classify(i_rx_header, i_rx_data);
  assign w_term_ok  = (w_in_type == BT_C) || (w_in_type == BT_S);
  assign w_dec_word = decode(r_a_type == BT_D, r_a_data);

  // State of the stage-A block, using the incoming block as lookahead
  always_comb begin
    w_fsm_state = RX_E;
    case (r_state)
      RX_INIT, RX_C, RX_T: begin
        if (r_a_type == BT_C)      w_fsm_state = RX_C;
        else if (r_a_type == BT_S) w_fsm_state = RX_D;
      end
      RX_D: begin
        if (r_a_type == BT_D)                   w_fsm_state = RX_D;
        else if (r_a_type == BT_T && w_term_ok) w_fsm_state = RX_T;
      end
      RX_E: begin
        if (r_a_type == BT_C)                   w_fsm_state = RX_C;
        else if (r_a_type == BT_D)              w_fsm_state = RX_D;
        else if (r_a_type == BT_T && w_term_ok) w_fsm_state = RX_T;
      end
      default: w_fsm_state = RX_E;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_full_nxt = r_a_full;
    w_a_data_nxt = r_a_data;
    w_a_type_nxt = r_a_type;
    w_rxd_nxt    = r_rxd;
    w_rxc_nxt    = r_rxc;
    w_err_nxt    = r_err_count;
    if (!i_block_lock) begin
      w_a_full_nxt = 1'b0;
      w_state_nxt  = RX_INIT;
      if (i_rx_valid) begin
        w_rxd_nxt = LBLOCK_RXD;
        w_rxc_nxt = LBLOCK_RXC;
      end
    end else if (i_rx_valid) begin
      w_a_full_nxt = 1'b1;
      w_a_data_nxt = i_rx_data;
      w_a_type_nxt = w_in_type;
      if (!r_a_full) begin
        w_state_nxt = RX_INIT;
        w_rxd_nxt   = LBLOCK_RXD;
        w_rxc_nxt   = LBLOCK_RXC;
      end else begin
        w_state_nxt = w_fsm_state;
        if (w_fsm_state == RX_E) begin
          w_rxd_nxt = ERR_RXD;
          w_rxc_nxt = 8'hFF;
          if (r_err_count != '1) w_err_nxt = r_err_count + ERR_CNT_WIDTH'(1);
        end else begin
          w_rxd_nxt = w_dec_word[63:0];
          w_rxc_nxt = w_dec_word[71:64];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= RX_INIT;
      r_a_full    <= 1'b0;
      r_a_data    <= '0;
      r_a_type    <= BT_E;
      r_rxd       <= LBLOCK_RXD;
      r_rxc       <= LBLOCK_RXC;
      r_valid     <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a_full    <= w_a_full_nxt;
      r_a_data    <= w_a_data_nxt;
      r_a_type    <= w_a_type_nxt;
      r_rxd       <= w_rxd_nxt;
      r_rxc       <= w_rxc_nxt;
      r_valid     <= i_rx_valid;
      r_err_count <= w_err_nxt;
    end
  end

  assign o_xgmii_rxd   = r_rxd;
  assign o_xgmii_rxc   = r_rxc;
  assign o_xgmii_valid = r_valid;
  assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_pcs_decoder_64b66b.sv
// Scoreboard bench for pcs_decoder_64b66b: a lane-table reference model predicts each
// XGMII word when a block is driven; a monitor pops and compares on o_xgmii_valid.
module tb_pcs_decoder_64b66b;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_rx_header;
  logic [63:0] i_rx_data;
  logic        i_rx_valid;
  logic        i_block_lock;
  logic [63:0] o_xgmii_rxd;
  logic [7:0]  o_xgmii_rxc;
  logic        o_xgmii_valid;
  logic [15:0] o_err_count;

  always #5 i_clk = ~i_clk;

  pcs_decoder_64b66b #(.ERR_CNT_WIDTH(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_header(i_rx_header), .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid), .i_block_lock(i_block_lock), .o_xgmii_rxd(o_xgmii_rxd),
    .o_xgmii_rxc(o_xgmii_rxc), .o_xgmii_valid(o_xgmii_valid), .o_err_count(o_err_count)
  );

  typedef struct { logic [63:0] rxd; logic [7:0] rxc; int err; } exp_t;
  exp_t q[$];
  int n_vec  = 0;
  int n_miss = 0;

  logic [6:0] VC [9] = '{7'h00, 7'h06, 7'h1e, 7'h2d, 7'h33, 7'h4b, 7'h55, 7'h66, 7'h78};
  logic [7:0] VR [9] = '{8'h07, 8'h06, 8'hFE, 8'h1C, 8'h3C, 8'h7C, 8'hBC, 8'hDC, 8'hF7};
  logic [7:0] TT [8] = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};

  // Reference model state
  bit          m_full;
  logic [1:0]  m_hdr;
  logic [63:0] m_data;
  string       m_st;
  int          m_err;

  function automatic int code_idx(logic [6:0] c);
    for (int i = 0; i < 9; i++) if (VC[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [7:0] m_rs(logic [6:0] c);
    int i;
    i = code_idx(c);
    return (i >= 0) ? VR[i] : 8'hFE;
  endfunction

  function automatic logic [7:0] m_oc(logic [3:0] o);
    if (o == 4'h0) return 8'h9C;
    if (o == 4'hF) return 8'h5C;
    return 8'hFE;
  endfunction

  function automatic int t_num(logic [7:0] bt);
    for (int i = 0; i < 8; i++) if (TT[i] == bt) return i;
    return -1;
  endfunction

  function automatic logic [6:0] code_at(logic [63:0] d, int k);
    return d[8+7*k +: 7];
  endfunction

  function automatic string m_class(logic [1:0] h, logic [63:0] d);
    if (h == 2'b10) return "D";
    if (h != 2'b01) return "E";
    if (d[7:0] == 8'h1e) begin
      for (int k = 0; k < 8; k++) if (code_idx(code_at(d, k)) < 0) return "E";
      return "C";
    end
    if (d[7:0] inside {8'h2d, 8'h55, 8'h4b}) return "C";
    if (d[7:0] inside {8'h33, 8'h66, 8'h78}) return "S";
    if (t_num(d[7:0]) >= 0) return "T";
    return "E";
  endfunction

  function automatic string m_next(string st, string cur, string nx);
    bit tok;
    tok = (cur == "T") && (nx == "C" || nx == "S");
    if (st == "RX_D") begin
      if (cur == "D") return "RX_D";
      if (tok) return "RX_T";
      return "RX_E";
    end
    if (st == "RX_E") begin
      if (cur == "C") return "RX_C";
      if (cur == "D") return "RX_D";
      if (tok) return "RX_T";
      return "RX_E";
    end
    if (cur == "C") return "RX_C";
    if (cur == "S") return "RX_D";
    return "RX_E";
  endfunction

  // Lane-by-lane translation of one non-error block
  task automatic m_decode(input logic [1:0] h, input logic [63:0] d,
                          output logic [63:0] rxd, output logic [7:0] rxc);
    logic [7:0] ln [8];
    bit         c [8];
    int         n;
    for (int i = 0; i < 8; i++) begin ln[i] = d[8*i +: 8]; c[i] = 1'b0; end
    if (h != 2'b10) begin
      case (d[7:0])
        8'h1e: for (int k = 0; k < 8; k++) begin ln[k] = m_rs(code_at(d, k)); c[k] = 1; end
        8'h2d: begin
          for (int k = 0; k < 4; k++) begin ln[k] = m_rs(code_at(d, k)); c[k] = 1; end
          ln[4] = m_oc(d[39:36]); c[4] = 1;
        end
        8'h33: begin
          for (int k = 0; k < 4; k++) begin ln[k] = m_rs(code_at(d, k)); c[k] = 1; end
          ln[4] = 8'hFB; c[4] = 1;
        end
        8'h66: begin ln[0] = m_oc(d[35:32]); c[0] = 1; ln[4] = 8'hFB; c[4] = 1; end
        8'h55: begin ln[0] = m_oc(d[35:32]); c[0] = 1; ln[4] = m_oc(d[39:36]); c[4] = 1; end
        8'h78: begin ln[0] = 8'hFB; c[0] = 1; end
        8'h4b: begin
          ln[0] = m_oc(d[35:32]); c[0] = 1;
          for (int k = 4; k < 8; k++) begin ln[k] = m_rs(code_at(d, k)); c[k] = 1; end
        end
        default: begin
          n = t_num(d[7:0]);
          for (int k = 0; k < 8; k++) begin
            if (k == n) begin ln[k] = 8'hFD; c[k] = 1; end
            else if (k > n) begin ln[k] = m_rs(code_at(d, k)); c[k] = 1; end
            else ln[k] = d[8*k+8 +: 8];
          end
        end
      endcase
    end
    for (int i = 0; i < 8; i++) begin rxd[8*i +: 8] = ln[i]; rxc[i] = c[i]; end
  endtask

  task automatic push(input logic [63:0] rxd, input logic [7:0] rxc);
    exp_t e;
    e.rxd = rxd; e.rxc = rxc; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic m_step(input bit v, input bit lk, input logic [1:0] h, input logic [63:0] d);
    string       cur, nx;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    if (!lk) begin
      m_full = 0;
      m_st   = "RX_INIT";
      if (v) push(64'h0100009C_0100009C, 8'h11);
    end else if (v) begin
      if (!m_full) begin
        m_st = "RX_INIT";
        push(64'h0100009C_0100009C, 8'h11);
      end else begin
        cur  = m_class(m_hdr, m_data);
        nx   = m_class(h, d);
        m_st = m_next(m_st, cur, nx);
        if (m_st == "RX_E") begin
          if (m_err < 65535) m_err++;
          push({8{8'hFE}}, 8'hFF);
        end else begin
          m_decode(m_hdr, m_data, rxd, rxc);
          push(rxd, rxc);
        end
      end
      m_hdr  = h;
      m_data = d;
      m_full = 1;
    end
  endtask

  task automatic m_reset();
    m_full = 0; m_st = "RX_INIT"; m_err = 0; m_hdr = '0; m_data = '0;
  endtask

  task automatic drive(input bit v, input bit lk, input logic [1:0] h, input logic [63:0] d);
    i_rx_valid = v; i_block_lock = lk; i_rx_header = h; i_rx_data = d;
    m_step(v, lk, h, d);
    @(posedge i_clk); #1;
  endtask

  task automatic send(input logic [65:0] b);
    drive(1'b1, 1'b1, b[65:64], b[63:0]);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [6:0] rnd_code();
    return VC[$urandom_range(0, 8)];
  endfunction

  function automatic logic [3:0] rnd_o();
    return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF;
  endfunction

  function automatic logic [65:0] blk_idle();
    return {2'b01, 56'h0, 8'h1e};
  endfunction

  function automatic logic [65:0] blk_d();
    return {2'b10, rnd64()};
  endfunction

  function automatic logic [65:0] blk_s0();
    logic [63:0] d;
    d = rnd64(); d[7:0] = 8'h78;
    return {2'b01, d};
  endfunction

  function automatic logic [65:0] blk_t(int n);
    logic [63:0] d;
    d = rnd64(); d[7:0] = TT[n];
    for (int k = n + 1; k < 8; k++) d[8+7*k +: 7] = rnd_code();
    return {2'b01, d};
  endfunction

  // Idle-like control blocks: 0x1e with legal codes or an ordered set
  function automatic logic [65:0] blk_ctl();
    logic [63:0] d;
    d = rnd64();
    case ($urandom_range(0, 3))
      0: begin d[7:0] = 8'h1e; for (int k = 0; k < 8; k++) d[8+7*k +: 7] = rnd_code(); end
      1: begin d[7:0] = 8'h2d; for (int k = 0; k < 4; k++) d[8+7*k +: 7] = rnd_code();
               d[39:36] = rnd_o(); end
      2: begin d[7:0] = 8'h4b; d[35:32] = rnd_o();
               for (int k = 4; k < 8; k++) d[8+7*k +: 7] = rnd_code(); end
      default: begin d[7:0] = 8'h55; d[35:32] = rnd_o(); d[39:36] = rnd_o(); end
    endcase
    return {2'b01, d};
  endfunction

  function automatic logic [65:0] blk_s_alt();
    logic [63:0] d;
    d = rnd64();
    if ($urandom_range(0, 1) == 0) begin
      d[7:0] = 8'h33;
      for (int k = 0; k < 4; k++) d[8+7*k +: 7] = rnd_code();
    end else begin
      d[7:0] = 8'h66; d[35:32] = rnd_o();
    end
    return {2'b01, d};
  endfunction

  function automatic logic [65:0] blk_bad();
    logic [63:0] d;
    d = rnd64();
    case ($urandom_range(0, 3))
      0: return {2'b11, d};
      1: return {2'b00, d};
      2: begin d[7:0] = 8'h00; return {2'b01, d}; end
      default: begin d[7:0] = 8'h1e; return {2'b01, d}; end
    endcase
  endfunction

  // Random block wrapper: stalls, lock drops and corruption
  task automatic send_rnd(input logic [65:0] b);
    int r;
    if ($urandom_range(0, 99) < 15) drive(1'b0, 1'b1, 2'($urandom()), rnd64());
    r = $urandom_range(0, 99);
    if (r < 2)       drive(1'($urandom()), 1'b0, b[65:64], b[63:0]);
    else if (r < 8)  send(blk_bad());
    else if (r < 11) send(blk_d());
    else             send(b);
  endtask

  task automatic chk_reset();
    n_vec++;
    if (o_xgmii_rxd !== 64'h0100009C_0100009C) begin
      n_miss++; $display("FAIL reset_rxd got %h want 0100009c0100009c", o_xgmii_rxd);
    end
    n_vec++;
    if (o_xgmii_rxc !== 8'h11) begin
      n_miss++; $display("FAIL reset_rxc got %h want 11", o_xgmii_rxc);
    end
    n_vec++;
    if (o_xgmii_valid !== 1'b0) begin
      n_miss++; $display("FAIL reset_valid got %b want 0", o_xgmii_valid);
    end
    n_vec++;
    if (o_err_count !== 16'd0) begin
      n_miss++; $display("FAIL reset_err got %0d want 0", o_err_count);
    end
  endtask

  // Monitor: compare every presented output word with the scoreboard head
  always @(negedge i_clk) begin
    exp_t e;
    if (i_reset === 1'b0 && o_xgmii_valid === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_word rxd=%h rxc=%h with nothing pending", o_xgmii_rxd, o_xgmii_rxc);
      end else begin
        e = q.pop_front();
        if (o_xgmii_rxd !== e.rxd || o_xgmii_rxc !== e.rxc || o_err_count !== 16'(e.err)) begin
          n_miss++;
          $display("FAIL word rxd=%h rxc=%h err=%0d want rxd=%h rxc=%h err=%0d",
                   o_xgmii_rxd, o_xgmii_rxc, o_err_count, e.rxd, e.rxc, e.err);
        end
      end
    end
  end

  task automatic directed();
    repeat (4) send(blk_idle());
    send(blk_s0()); send(blk_d()); send(blk_d()); send(blk_t(3)); send(blk_idle()); send(blk_idle());
    send(blk_s0()); send(blk_d()); send({2'b11, rnd64()}); send(blk_idle()); send(blk_s0());
    send(blk_d()); send(blk_t(7)); send(blk_idle());
    send(blk_s0()); send(blk_d()); send(blk_t(7)); send(blk_d()); send(blk_d()); send(blk_t(2));
    send(blk_idle());
    send(blk_s0()); send(blk_d()); drive(1'b0, 1'b1, 2'b10, rnd64()); send(blk_d());
    send(blk_t(4)); send(blk_idle());
    send(blk_s0()); send(blk_d()); drive(1'b1, 1'b0, 2'b10, rnd64());
    drive(1'b0, 1'b0, 2'b10, rnd64()); send(blk_d()); send(blk_idle()); send(blk_idle());
    send(blk_s0()); send(blk_t(0)); send(blk_idle()); send(blk_idle());
  endtask

  initial begin
    i_reset = 1'b1; i_rx_valid = 1'b0; i_block_lock = 1'b0; i_rx_header = '0; i_rx_data = '0;
    m_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk_reset();
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    directed();

    repeat (300) begin
      repeat ($urandom_range(0, 3)) send_rnd(($urandom_range(0, 1) == 0) ? blk_idle() : blk_ctl());
      send_rnd(($urandom_range(0, 4) == 0) ? blk_s_alt() : blk_s0());
      repeat ($urandom_range(0, 5)) send_rnd(blk_d());
      send_rnd(blk_t($urandom_range(0, 7)));
    end

    // Asynchronous reset in the middle of a frame
    send(blk_s0()); send(blk_d());
    @(negedge i_clk); #1;
    i_rx_valid = 1'b0;
    i_reset = 1'b1;
    #1;
    chk_reset();
    q.delete();
    m_reset();
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    directed();

    repeat (4) drive(1'b0, 1'b1, 2'b01, 64'h0);
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain got %0d words outstanding want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
